// File: rtl/ahb_sram_if.sv
// AHB-Lite bus bundle between a master/decoder and the SRAM slave.
interface ahb_sram_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave: pipelined address/data phases,
// programmable wait states, byte/half/word writes, two-cycle ERROR response.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no data phase pending, HREADYOUT=1, HRESP=OKAY
//   WAIT    | legal data phase stalled, HREADYOUT=0, counter running
//   LAST    | final cycle of a legal data phase, write commits at its end
//   ERR1    | first ERROR cycle, HREADYOUT=0, HRESP=1
//   ERR2    | second ERROR cycle, HREADYOUT=1, HRESP=1
module ahb_sram_slave #(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic      clk,
  input  logic      reset,
  ahb_sram_if.slave bus
);
  localparam int         WORDS   = 1 << (MEM_AW - 2);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic [31:0]       mem [WORDS];

  logic              accept;
  logic              illegal;
  logic              commit;
  logic              load_rd;
  logic [MEM_AW-3:0] wr_idx;
  logic [MEM_AW-3:0] rd_idx;
  logic [3:0]        wr_be;
  logic [31:0]       rd_word;
  logic              unused_bits;

  // Upper address bits alias the array; burst type and BUSY/IDLE distinction carry no meaning here.
  assign unused_bits = ^{bus.HBURST, bus.HADDR[31:MEM_AW], bus.HTRANS[0]};

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;

  // Qualify the address phase on the bus and judge its size/alignment.
  always_comb begin
    accept  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    illegal = (bus.HSIZE > 3'b010) ||
              (bus.HSIZE == 3'b001 && bus.HADDR[0]) ||
              (bus.HSIZE == 3'b010 && bus.HADDR[1:0] != 2'b00);
  end

  // Next state, latched address phase and next registered bus outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, LAST and ERR2 are the cycles where a new address phase may be taken.
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = bus.HADDR[MEM_AW-1:0];
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE;
          if (illegal) begin
            state_d = ST_ERR1;
            write_d = 1'b0;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_LAST;
          end
        end
      end
    endcase
    hreadyout_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
    hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2);
  end

  // Byte enables of the pending write and the commit strobe.
  always_comb begin
    wr_idx = addr_q[MEM_AW-1:2];
    case (size_q)
      3'b000:  wr_be = 4'b0001 << addr_q[1:0];
      3'b001:  wr_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
    commit = (state_q == ST_LAST) && write_q && !reset;
  end

  // Read load on entry to LAST, forwarding lanes written at the same edge to the same word.
  always_comb begin
    rd_idx  = addr_d[MEM_AW-1:2];
    load_rd = (state_d == ST_LAST) && !write_d;
    rd_word = mem[rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (commit && wr_be[i] && (wr_idx == rd_idx)) rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end
    hrdata_d = load_rd ? rd_word : hrdata_q;
  end

  // FSM state, latched address phase and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'b000;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Byte-lane write into the array at the end of a write data phase.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a two-wait instance behind one
// master, checked against a byte-addressed reference memory.
module tb_ahb_sram_slave;
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [2:0]  hburst = 3'b000;
  logic [31:0] hwdata = 32'd0;
  logic        hready_kill = 1'b0;
  int          sel_ws = 0;

  int          checks = 0;
  int          errors = 0;
  xfer_t       xq[$];
  logic [7:0]  ref_mem [2][4096];
  logic [31:0] last_rd [2];

  logic        hreadyout_m, hresp_m, hready_bus;
  logic [31:0] hrdata_m;

  always #5 clk = ~clk;

  ahb_sram_if if0 ();
  ahb_sram_if if2 ();

  assign if0.HSEL = hsel && (sel_ws == 0);
  assign if2.HSEL = hsel && (sel_ws != 0);
  assign if0.HADDR = haddr;   assign if2.HADDR = haddr;
  assign if0.HTRANS = htrans; assign if2.HTRANS = htrans;
  assign if0.HWRITE = hwrite; assign if2.HWRITE = hwrite;
  assign if0.HSIZE = hsize;   assign if2.HSIZE = hsize;
  assign if0.HBURST = hburst; assign if2.HBURST = hburst;
  assign if0.HWDATA = hwdata; assign if2.HWDATA = hwdata;
  assign hreadyout_m = (sel_ws != 0) ? if2.HREADYOUT : if0.HREADYOUT;
  assign hresp_m     = (sel_ws != 0) ? if2.HRESP : if0.HRESP;
  assign hrdata_m    = (sel_ws != 0) ? if2.HRDATA : if0.HRDATA;
  assign hready_bus  = !hready_kill && hreadyout_m;
  assign if0.HREADY = hready_bus;
  assign if2.HREADY = hready_bus;

  ahb_sram_slave #(.MEM_AW(12), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  ahb_sram_slave #(.MEM_AW(12), .WAIT_STATES(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  function automatic int ws_of(input int s);
    return (s != 0) ? 2 : 0;
  endfunction

  function automatic bit is_active(input xfer_t x);
    return x.sel && x.trans[1];
  endfunction

  function automatic bit is_illegal(input xfer_t x);
    int n;
    n = 1 << x.size;
    return is_active(x) && (x.size > 3'd2 || (int'(x.addr[11:0]) % n) != 0);
  endfunction

  function automatic logic [31:0] model_word(input int s, input logic [31:0] addr);
    int b;
    b = (int'(addr[11:0]) / 4) * 4;
    return {ref_mem[s][b+3], ref_mem[s][b+2], ref_mem[s][b+1], ref_mem[s][b]};
  endfunction

  function automatic void model_write(input int s, input xfer_t x);
    int base, a;
    base = int'(x.addr[11:0]);
    for (int b = 0; b < (1 << x.size); b++) begin
      a = base + b;
      ref_mem[s][a] = x.wdata[8*(a%4) +: 8];
    end
  endfunction

  function automatic void push(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.addr = addr; x.wr = wr; x.size = size; x.wdata = wdata;
    xq.push_back(x);
  endfunction

  task automatic present(input int ai);
    if (ai < xq.size()) begin
      hsel   = xq[ai].sel;
      haddr  = xq[ai].addr;
      htrans = xq[ai].trans;
      hwrite = xq[ai].wr;
      hsize  = xq[ai].size;
      hburst = (xq[ai].trans == 2'b11) ? 3'b001 : 3'b000;
    end else begin
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; haddr = 32'd0; hburst = 3'b000;
    end
  endtask

  // Pipelined master: drives the queued transfers and checks every data-phase cycle.
  task automatic run_xfers(output int data_cycles);
    int ai, dp, dcyc, len, budget, s;
    logic rdy;
    logic [31:0] exp_rd;
    bit act, ill;
    ai = 0; dp = -1; dcyc = 0; budget = 2000; s = sel_ws;
    data_cycles = 0;
    present(0);
    while ((ai < xq.size() || dp >= 0) && budget > 0) begin
      budget--;
      @(negedge clk);
      rdy = hready_bus;
      if (dp >= 0) begin
        act = is_active(xq[dp]);
        ill = is_illegal(xq[dp]);
        dcyc++;
        len = ill ? 2 : (act ? ws_of(s) + 1 : 1);
        if (act && !ill) data_cycles++;
        exp_rd = last_rd[s];
        if (dcyc == len && act && !ill && !xq[dp].wr) begin
          exp_rd = model_word(s, xq[dp].addr);
          last_rd[s] = exp_rd;
        end
        checks++;
        if (rdy !== (dcyc >= len))
          $display("FAIL hreadyout ws%0d xfer %0d cyc %0d: got %b expected %b", ws_of(s), dp, dcyc, rdy, dcyc >= len);
        if (rdy !== (dcyc >= len)) errors++;
        checks++;
        if (hresp_m !== ill) begin
          errors++;
          $display("FAIL hresp ws%0d xfer %0d cyc %0d: got %b expected %b", ws_of(s), dp, dcyc, hresp_m, ill);
        end
        checks++;
        if (hrdata_m !== exp_rd) begin
          errors++;
          $display("FAIL hrdata ws%0d xfer %0d addr %h cyc %0d: got %h expected %h",
                   ws_of(s), dp, xq[dp].addr, dcyc, hrdata_m, exp_rd);
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (dp >= 0 && is_active(xq[dp]) && !is_illegal(xq[dp]) && xq[dp].wr) model_write(s, xq[dp]);
        if (ai < xq.size()) begin
          dp = ai; ai++; dcyc = 0;
        end else begin
          dp = -1;
        end
        present(ai);
        hwdata = (dp >= 0 && xq[dp].wr) ? xq[dp].wdata : $urandom;
      end
    end
    if (budget == 0) begin
      errors++;
      $display("FAIL run_timeout ws%0d: transfers still pending got %0d expected 0", ws_of(s), xq.size() - ai);
    end
    xq.delete();
    present(0);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (if0.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout0: got %b expected 1", if0.HREADYOUT); end
    checks++; if (if0.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp0: got %b expected 0", if0.HRESP); end
    checks++; if (if0.HRDATA !== 32'd0) begin errors++; $display("FAIL reset_hrdata0: got %h expected 0", if0.HRDATA); end
    checks++; if (if2.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout2: got %b expected 1", if2.HREADYOUT); end
    checks++; if (if2.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp2: got %b expected 0", if2.HRESP); end
    checks++; if (if2.HRDATA !== 32'd0) begin errors++; $display("FAIL reset_hrdata2: got %h expected 0", if2.HRDATA); end
    reset = 1'b0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    @(posedge clk); #1;
  endtask

  task automatic init_mem;
    int dc;
    for (int s = 0; s < 2; s++) begin
      sel_ws = s;
      for (int w = 0; w < 64; w++) push(1'b1, (w == 0) ? 2'b10 : 2'b11, 32'(w * 4), 1'b1, 3'b010, $urandom);
      run_xfers(dc);
    end
  endtask

  task automatic test_word_bypass;
    int dc;
    sel_ws = 0;
    push(1'b1, 2'b10, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF);
    push(1'b1, 2'b10, 32'h10, 1'b0, 3'b010, 32'h0);
    run_xfers(dc);
    checks++;
    if (hrdata_m !== 32'hDEADBEEF) begin errors++; $display("FAIL word_bypass: got %h expected deadbeef", hrdata_m); end
  endtask

  task automatic test_byte_lane;
    int dc;
    sel_ws = 0;
    push(1'b1, 2'b10, 32'h10, 1'b1, 3'b010, 32'h11223344);
    push(1'b1, 2'b10, 32'h11, 1'b1, 3'b000, 32'h5555AA55);
    push(1'b1, 2'b10, 32'h10, 1'b0, 3'b010, 32'h0);
    run_xfers(dc);
    checks++;
    if (hrdata_m !== 32'h1122AA44) begin errors++; $display("FAIL byte_lane: got %h expected 1122aa44", hrdata_m); end
  endtask

  task automatic test_illegal;
    int dc;
    sel_ws = 0;
    push(1'b1, 2'b10, 32'h20, 1'b1, 3'b010, 32'h55667788);
    push(1'b1, 2'b10, 32'h21, 1'b1, 3'b001, 32'hFFFFFFFF);
    push(1'b1, 2'b10, 32'h22, 1'b1, 3'b011, 32'hFFFFFFFF);
    push(1'b1, 2'b10, 32'h20, 1'b0, 3'b010, 32'h0);
    run_xfers(dc);
    checks++;
    if (hrdata_m !== 32'h55667788) begin errors++; $display("FAIL illegal_nowrite: got %h expected 55667788", hrdata_m); end
  endtask

  task automatic test_no_transfer;
    int dc;
    logic [31:0] exp;
    sel_ws = 0;
    exp = model_word(0, 32'h30);
    push(1'b1, 2'b00, 32'h30, 1'b1, 3'b010, ~exp);
    push(1'b1, 2'b01, 32'h30, 1'b1, 3'b010, ~exp);
    push(1'b0, 2'b10, 32'h30, 1'b1, 3'b010, ~exp);
    push(1'b1, 2'b10, 32'h30, 1'b0, 3'b010, 32'h0);
    run_xfers(dc);
    checks++;
    if (hrdata_m !== exp) begin errors++; $display("FAIL no_transfer: got %h expected %h", hrdata_m, exp); end
  endtask

  task automatic test_hready_low;
    int dc;
    logic [31:0] exp;
    sel_ws = 0;
    exp = model_word(0, 32'h80);
    hready_kill = 1'b1;
    hsel = 1'b1; haddr = 32'h80; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; hwdata = ~exp;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (hreadyout_m !== 1'b1) begin errors++; $display("FAIL hready_low_ready: got %b expected 1", hreadyout_m); end
      checks++; if (hresp_m !== 1'b0) begin errors++; $display("FAIL hready_low_resp: got %b expected 0", hresp_m); end
      checks++; if (hrdata_m !== last_rd[0]) begin errors++; $display("FAIL hready_low_rdata: got %h expected %h", hrdata_m, last_rd[0]); end
      @(posedge clk); #1;
    end
    present(0);
    hready_kill = 1'b0;
    push(1'b1, 2'b10, 32'h80, 1'b0, 3'b010, 32'h0);
    run_xfers(dc);
    checks++;
    if (hrdata_m !== exp) begin errors++; $display("FAIL hready_low_nowrite: got %h expected %h", hrdata_m, exp); end
  endtask

  task automatic test_wait_states;
    int dc;
    sel_ws = 1;
    push(1'b1, 2'b10, 32'h14, 1'b0, 3'b010, 32'h0);
    run_xfers(dc);
    checks++;
    if (dc !== 3) begin errors++; $display("FAIL ws2_single_cycles: got %0d expected 3", dc); end
    push(1'b1, 2'b10, 32'h50, 1'b0, 3'b010, 32'h0);
    for (int b = 1; b < 4; b++) push(1'b1, 2'b11, 32'(32'h50 + 4 * b), 1'b0, 3'b010, 32'h0);
    run_xfers(dc);
    checks++;
    if (dc !== 12) begin errors++; $display("FAIL ws2_burst_cycles: got %0d expected 12", dc); end
  endtask

  task automatic test_reset_mid_write;
    int dc;
    sel_ws = 1;
    push(1'b1, 2'b10, 32'h40, 1'b1, 3'b010, 32'h12345678);
    run_xfers(dc);
    @(posedge clk); #1;
    hsel = 1'b1; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    present(0);
    hwdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (hreadyout_m !== 1'b0) begin errors++; $display("FAIL midwrite_wait: got %b expected 0", hreadyout_m); end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (hreadyout_m !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", hreadyout_m); end
    checks++; if (hresp_m !== 1'b0) begin errors++; $display("FAIL midreset_resp: got %b expected 0", hresp_m); end
    checks++; if (hrdata_m !== 32'd0) begin errors++; $display("FAIL midreset_rdata: got %h expected 0", hrdata_m); end
    reset = 1'b0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    @(posedge clk); #1;
    push(1'b1, 2'b10, 32'h40, 1'b0, 3'b010, 32'h0);
    run_xfers(dc);
    checks++;
    if (hrdata_m !== 32'h12345678) begin errors++; $display("FAIL midreset_nowrite: got %h expected 12345678", hrdata_m); end
  endtask

  task automatic test_random;
    int dc, kind;
    logic [2:0] sz;
    logic [31:0] a;
    logic sl;
    for (int s = 0; s < 2; s++) begin
      sel_ws = s;
      for (int k = 0; k < 40; k++) begin
        kind = $urandom_range(0, 9);
        sz = 3'($urandom_range(0, 2));
        a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
        if (kind == 0) sz = 3'($urandom_range(3, 7));
        else if (kind < 8) a = a & ~((32'd1 << sz) - 32'd1);
        if (kind == 9) begin
          sl = 1'($urandom_range(0, 1));
          push(sl, sl ? 2'($urandom_range(0, 1)) : 2'b10, a, 1'($urandom_range(0, 1)), sz, $urandom);
        end else begin
          push(1'b1, 2'($urandom_range(2, 3)), a, 1'($urandom_range(0, 1)), sz, $urandom);
        end
      end
      run_xfers(dc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    init_mem();
    test_word_bypass();
    test_byte_lane();
    test_illegal();
    test_no_transfer();
    test_hready_low();
    test_wait_states();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
